// File: rtl/key_counter_ctrl_pkg.sv
// Shared definitions for the key counter controller.
// Contents:
//   key_state_t          - per-key repeat FSM states
//   DEF_DEBOUNCE_CYCLES  - 10 ms at 50 MHz
//   DEF_REPEAT_DELAY     - 0.5 s hold before the first auto-repeat
//   DEF_REPEAT_RATE      - 0.1 s between auto-repeat steps
package key_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FIRST     = 2'd1,
    ST_HOLD_WAIT = 2'd2,
    ST_REPEAT    = 2'd3
  } key_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

endpackage

// File: rtl/key_debounce.sv
// One push-button front end: 2-flop synchroniser, debouncer and
// auto-repeat FSM.
// Ports:
//   CLOCK_50 - clock, rising edge
//   RESET_N  - synchronous active-low reset
//   key_n    - raw asynchronous key, 0 = pressed
//   held     - debounced key state, 1 = pressed
//   step     - one-cycle step request (combinational from FSM state/timer)
module key_debounce
  import key_counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key_n,
  output logic held,
  output logic step
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

  logic [1:0]    r_sync;
  logic          r_held;
  logic [DW-1:0] r_db_cnt;
  logic [TW-1:0] r_timer;
  key_state_t    r_state;

  logic w_pressed;
  logic w_differ;
  logic w_flip;

  assign w_pressed = ~r_sync[1];
  assign w_differ  = (w_pressed != r_held);
  // Flip on the cycle that completes the stable run, so the FSM can
  // react to the edge on the same clock the debounced level changes.
  assign w_flip    = w_differ && (r_db_cnt == DB_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_sync   <= 2'b11;
      r_held   <= 1'b0;
      r_db_cnt <= '0;
      r_timer  <= '0;
      r_state  <= ST_IDLE;
    end else begin
      r_sync <= {r_sync[0], key_n};

      if (w_flip) begin
        r_held   <= ~r_held;
        r_db_cnt <= '0;
      end else if (w_differ) begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end else begin
        r_db_cnt <= '0;
      end

      if (w_flip && r_held) begin
        // Debounced release aborts from any state, no step issued.
        r_state <= ST_IDLE;
        r_timer <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_timer <= '0;
            if (w_flip) r_state <= ST_FIRST;
          end
          ST_FIRST: begin
            r_timer <= '0;
            r_state <= ST_HOLD_WAIT;
          end
          ST_HOLD_WAIT: begin
            if (r_timer == DELAY_LAST) begin
              r_timer <= '0;
              r_state <= ST_REPEAT;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (r_timer == RATE_LAST) r_timer <= '0;
            else                      r_timer <= r_timer + 1'b1;
          end
          default: begin
            r_timer <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    step = 1'b0;
    unique case (r_state)
      ST_FIRST:     step = 1'b1;
      ST_HOLD_WAIT: step = (r_timer == DELAY_LAST);
      ST_REPEAT:    step = (r_timer == RATE_LAST);
      default:      step = 1'b0;
    endcase
  end

  assign held = r_held;

endmodule

// File: rtl/key_counter_ctrl.sv
// Two-key up/down counter controller.
// Ports:
//   CLOCK_50   - clock, rising edge
//   RESET_N    - synchronous active-low reset
//   KEY_UP_N   - raw up key, 0 = pressed
//   KEY_DOWN_N - raw down key, 0 = pressed
//   LOAD       - parallel load strobe (highest priority)
//   LOAD_VALUE - value loaded into COUNT
//   COUNT      - counter value
//   INC_PULSE  - COUNT incremented this cycle
//   DEC_PULSE  - COUNT decremented this cycle
//   UP_HELD    - debounced up key state
//   DOWN_HELD  - debounced down key state
module key_counter_ctrl
  import key_counter_ctrl_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int WRAP            = 1
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             KEY_UP_N,
  input  logic             KEY_DOWN_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  output logic [WIDTH-1:0] COUNT,
  output logic             INC_PULSE,
  output logic             DEC_PULSE,
  output logic             UP_HELD,
  output logic             DOWN_HELD
);

  localparam logic [WIDTH-1:0] CMAX = {WIDTH{1'b1}};

  logic             w_up_step;
  logic             w_down_step;
  logic [WIDTH-1:0] r_count;
  logic             r_inc;
  logic             r_dec;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_key_up (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .key_n   (KEY_UP_N),
    .held    (UP_HELD),
    .step    (w_up_step)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_key_down (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .key_n   (KEY_DOWN_N),
    .held    (DOWN_HELD),
    .step    (w_down_step)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_count <= '0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
    end else begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      if (LOAD) begin
        // Load wins; any step requested this cycle is dropped.
        r_count <= LOAD_VALUE;
      end else if (w_up_step && !w_down_step) begin
        if (r_count != CMAX) begin
          r_count <= r_count + 1'b1;
          r_inc   <= 1'b1;
        end else if (WRAP != 0) begin
          r_count <= '0;
          r_inc   <= 1'b1;
        end
      end else if (w_down_step && !w_up_step) begin
        if (r_count != '0) begin
          r_count <= r_count - 1'b1;
          r_dec   <= 1'b1;
        end else if (WRAP != 0) begin
          r_count <= CMAX;
          r_dec   <= 1'b1;
        end
      end
      // Simultaneous up and down requests cancel.
    end
  end

  assign COUNT     = r_count;
  assign INC_PULSE = r_inc;
  assign DEC_PULSE = r_dec;

endmodule

// File: tb/tb_key_counter_ctrl.sv
module tb_key_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_up_n;
  logic       key_down_n;
  logic       load;
  logic [7:0] load_value;

  logic [7:0] count_w, count_s;
  logic       inc_w, dec_w, up_w, down_w;
  logic       inc_s, dec_s, up_s, down_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_counter_ctrl #(
    .WIDTH(8), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .WRAP(1)
  ) dut_w (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY_UP_N(key_up_n), .KEY_DOWN_N(key_down_n),
    .LOAD(load), .LOAD_VALUE(load_value), .COUNT(count_w), .INC_PULSE(inc_w),
    .DEC_PULSE(dec_w), .UP_HELD(up_w), .DOWN_HELD(down_w)
  );

  key_counter_ctrl #(
    .WIDTH(8), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .WRAP(0)
  ) dut_s (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY_UP_N(key_up_n), .KEY_DOWN_N(key_down_n),
    .LOAD(load), .LOAD_VALUE(load_value), .COUNT(count_s), .INC_PULSE(inc_s),
    .DEC_PULSE(dec_s), .UP_HELD(up_s), .DOWN_HELD(down_s)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    load       = 1'b0;
    load_value = 8'h00;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load       = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({count_w, inc_w, dec_w, up_w, down_w} !== 12'h000) begin
      errors++;
      $display("FAIL reset: count=%h inc=%b dec=%b up=%b down=%b, want all 0",
               count_w, inc_w, dec_w, up_w, down_w);
    end
    $display("reset: count=%h", count_w);
  endtask

  // Key down for cycles 0..7, released at cycle 8.
  task automatic test_clean_press();
    logic [7:0] exp_cnt;
    logic       exp_inc, exp_held;
    do_reset();
    key_up_n = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 8) key_up_n = 1'b1;
      exp_held = (k >= 6) && (k < 14);
      exp_inc  = (k == 7);
      exp_cnt  = (k >= 7) ? 8'h01 : 8'h00;
      checks++;
      if (up_w !== exp_held || inc_w !== exp_inc || count_w !== exp_cnt || dec_w !== 1'b0) begin
        errors++;
        $display("FAIL clean_press cycle %0d: held=%b inc=%b dec=%b count=%h, want held=%b inc=%b dec=0 count=%h",
                 k, up_w, inc_w, dec_w, count_w, exp_held, exp_inc, exp_cnt);
      end
    end
    $display("clean_press: final count=%h", count_w);
  endtask

  // Pin toggles 0,0,1,1,... for cycles 0..19, then stays 0.
  task automatic test_bounce();
    int incs;
    incs = 0;
    do_reset();
    key_up_n = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k < 20) key_up_n = ((k % 4) >= 2);
      else        key_up_n = 1'b0;
      if (inc_w === 1'b1) incs++;
      if (k <= 26) begin
        checks++;
        if (inc_w !== 1'b0 || count_w !== 8'h00) begin
          errors++;
          $display("FAIL bounce_quiet cycle %0d: inc=%b count=%h, want inc=0 count=00",
                   k, inc_w, count_w);
        end
      end
    end
    checks++;
    if (incs != 1 || count_w !== 8'h01) begin
      errors++;
      $display("FAIL bounce_final: incs=%0d count=%h, want incs=1 count=01", incs, count_w);
    end
    $display("bounce: incs=%0d count=%h", incs, count_w);
  endtask

  // Down key held for cycles 0..39 starting from COUNT=05.
  task automatic test_auto_repeat();
    int   exp_cycles[10] = '{7, 17, 20, 23, 26, 29, 32, 35, 38, 41};
    logic exp_dec;
    do_reset();
    do_load(8'h05);
    key_down_n = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (k == 40) key_down_n = 1'b1;
      exp_dec = 1'b0;
      for (int j = 0; j < 10; j++) if (exp_cycles[j] == k) exp_dec = 1'b1;
      checks++;
      if (dec_w !== exp_dec || inc_w !== 1'b0) begin
        errors++;
        $display("FAIL auto_repeat cycle %0d: dec=%b inc=%b, want dec=%b inc=0",
                 k, dec_w, inc_w, exp_dec);
      end
    end
    checks++;
    if (count_w !== 8'hFB) begin
      errors++;
      $display("FAIL auto_repeat_count: count=%h, want FB", count_w);
    end
    $display("auto_repeat: count=%h", count_w);
  endtask

  task automatic test_wrap_saturate();
    // Up from FF.
    do_reset();
    do_load(8'hFF);
    key_up_n = 1'b0;
    repeat (7) tick();
    checks++;
    if (count_w !== 8'h00 || inc_w !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up: count=%h inc=%b, want 00 1", count_w, inc_w);
    end
    checks++;
    if (count_s !== 8'hFF || inc_s !== 1'b0) begin
      errors++;
      $display("FAIL sat_up: count=%h inc=%b, want FF 0", count_s, inc_s);
    end
    // Down from 00.
    do_reset();
    do_load(8'h00);
    key_down_n = 1'b0;
    repeat (7) tick();
    checks++;
    if (count_w !== 8'hFF || dec_w !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down: count=%h dec=%b, want FF 1", count_w, dec_w);
    end
    checks++;
    if (count_s !== 8'h00 || dec_s !== 1'b0) begin
      errors++;
      $display("FAIL sat_down: count=%h dec=%b, want 00 0", count_s, dec_s);
    end
    $display("wrap_saturate: wrap up/down -> %h, sat count=%h", count_w, count_s);
  endtask

  task automatic test_simultaneous();
    do_reset();
    key_up_n   = 1'b0;
    key_down_n = 1'b0;
    repeat (6) tick();
    checks++;
    if (up_w !== 1'b1 || down_w !== 1'b1) begin
      errors++;
      $display("FAIL both_held: up=%b down=%b, want 1 1", up_w, down_w);
    end
    tick();
    checks++;
    if (count_w !== 8'h00 || inc_w !== 1'b0 || dec_w !== 1'b0) begin
      errors++;
      $display("FAIL both_cancel: count=%h inc=%b dec=%b, want 00 0 0", count_w, inc_w, dec_w);
    end
    // LOAD coinciding with the first up step (step request is in cycle 6).
    do_reset();
    key_up_n = 1'b0;
    repeat (6) tick();
    load       = 1'b1;
    load_value = 8'h3C;
    tick();
    load = 1'b0;
    checks++;
    if (count_w !== 8'h3C || inc_w !== 1'b0) begin
      errors++;
      $display("FAIL load_priority: count=%h inc=%b, want 3C 0", count_w, inc_w);
    end
    $display("simultaneous: load count=%h", count_w);
  endtask

  task automatic test_reset_mid_repeat();
    do_reset();
    key_up_n = 1'b0;
    repeat (20) tick();
    checks++;
    if (count_w !== 8'h03) begin
      errors++;
      $display("FAIL pre_reset_count: count=%h, want 03", count_w);
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({count_w, inc_w, dec_w, up_w, down_w} !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset: count=%h inc=%b dec=%b up=%b down=%b, want all 0",
               count_w, inc_w, dec_w, up_w, down_w);
    end
    // RESET_N high from cycle 22; fresh step visible at cycle 29.
    for (int k = 23; k <= 29; k++) begin
      tick();
      checks++;
      if (k < 29 && (count_w !== 8'h00 || inc_w !== 1'b0)) begin
        errors++;
        $display("FAIL post_reset_quiet cycle %0d: count=%h inc=%b, want 00 0", k, count_w, inc_w);
      end else if (k == 29 && (count_w !== 8'h01 || inc_w !== 1'b1)) begin
        errors++;
        $display("FAIL post_reset_step: count=%h inc=%b, want 01 1", count_w, inc_w);
      end
    end
    $display("reset_mid_repeat: count=%h", count_w);
  endtask

  initial begin
    rst_n      = 1'b0;
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    load       = 1'b0;
    load_value = 8'h00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_wrap_saturate();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
